// File: rtl/imem_block_server_pkg.sv
// Shared definitions for the instruction memory and the instruction cache.
// State encoding and block/address geometry live here.
package imem_block_server_pkg;

    localparam int BLOCK_BYTES  = 16;
    localparam int BLOCK_W      = 128;
    localparam int BLOCK_ADDR_W = 6;
    localparam int BYTE_ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide storage with one write port and a combinational
// whole-block read port.
module imem_byte_array
    import imem_block_server_pkg::*;
#(
    parameter int NUM_BLOCKS = 64
) (
    input  logic                    clock,
    input  logic                    i_we,
    input  logic [BYTE_ADDR_W-1:0]  i_waddr,
    input  logic [7:0]              i_wdata,
    input  logic [BLOCK_ADDR_W-1:0] i_raddr,
    output logic [BLOCK_W-1:0]      o_rdata
);

    logic [7:0] r_mem [NUM_BLOCKS*BLOCK_BYTES];

    // Contents are deliberately not reset; the preload port fills them.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            o_rdata[8*i +: 8] = r_mem[{i_raddr, i[3:0]}];
        end
    end

endmodule

// File: rtl/imem_block_server.sv
// Instruction memory serving one 128-bit block per request after a
// fixed latency, with a byte preload port usable only while idle.
module imem_block_server
    import imem_block_server_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int NUM_BLOCKS = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic [BLOCK_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]      mem_inst,
    output logic                    mem_busywait,
    input  logic                    load_en,
    input  logic [BYTE_ADDR_W-1:0]  load_addr,
    input  logic [7:0]              load_byte
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    imem_state_t               r_state;
    imem_state_t               w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [BLOCK_ADDR_W-1:0]   r_addr;
    logic [BLOCK_ADDR_W-1:0]   w_addr_nxt;
    logic [BLOCK_W-1:0]        r_inst;
    logic [BLOCK_W-1:0]        w_inst_nxt;
    logic [BLOCK_W-1:0]        w_block;
    logic                      w_we;
    logic                      w_busy;

    imem_byte_array #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_byte),
        .i_raddr (r_addr),
        .o_rdata (w_block)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_inst  <= w_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_inst_nxt  = r_inst;
        w_we        = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy = mem_read;
                // Write lands at this edge, so a read accepted now sees it.
                w_we   = load_en & ~reset;
                if (mem_read) begin
                    w_addr_nxt  = mem_address;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_busy = mem_read;
                if (!mem_read) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_inst_nxt  = w_block;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_inst     = r_inst;
    assign mem_busywait = w_busy;

endmodule

// File: tb/tb_imem_block_server.sv
// Randomized and directed bench for imem_block_server; two builds
// (LATENCY 5 and 1) checked every cycle against a timeline model.
module tb_imem_block_server;

    localparam int LAT0 = 5;
    localparam int LAT1 = 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rd [2];
    logic [5:0]   ad [2];
    logic         le [2];
    logic [9:0]   la [2];
    logic [7:0]   lb [2];
    logic         bw [2];
    logic [127:0] inst [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: byte image plus request timeline per build.
    logic [7:0]   mmem [2][1024];
    int           lat [2];
    bit           m_pend [2];
    bit           m_resp [2];
    int           m_acc [2];
    logic [5:0]   m_addr [2];
    logic [127:0] m_inst [2];
    int           cyc = 0;
    bit           mdl_ok = 0;

    always #5 clock = ~clock;

    imem_block_server #(.LATENCY(LAT0), .NUM_BLOCKS(64)) dut0 (
        .clock(clock), .reset(reset), .mem_read(rd[0]),
        .mem_address(ad[0]), .mem_inst(inst[0]),
        .mem_busywait(bw[0]), .load_en(le[0]),
        .load_addr(la[0]), .load_byte(lb[0])
    );

    imem_block_server #(.LATENCY(LAT1), .NUM_BLOCKS(64)) dut1 (
        .clock(clock), .reset(reset), .mem_read(rd[1]),
        .mem_address(ad[1]), .mem_inst(inst[1]),
        .mem_busywait(bw[1]), .load_en(le[1]),
        .load_addr(la[1]), .load_byte(lb[1])
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] blk(input int d, input logic [5:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = mmem[d][{a, 4'(i)}];
        end
        return r;
    endfunction

    always @(posedge clock) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_pend[d] = 0;
                m_resp[d] = 0;
                m_inst[d] = '0;
            end else if (m_resp[d]) begin
                m_resp[d] = 0;
            end else if (m_pend[d]) begin
                if (!rd[d]) begin
                    m_pend[d] = 0;
                end else if (cyc - m_acc[d] == lat[d]) begin
                    m_inst[d] = blk(d, m_addr[d]);
                    m_resp[d] = 1;
                    m_pend[d] = 0;
                end
            end else begin
                if (le[d]) mmem[d][la[d]] = lb[d];
                if (rd[d]) begin
                    m_pend[d] = 1;
                    m_acc[d]  = cyc;
                    m_addr[d] = ad[d];
                end
            end
        end
        if (reset) mdl_ok = 1;
    end

    always @(negedge clock) begin
        if (mdl_ok) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busywait%0d", d), 128'(bw[d]),
                    128'(m_resp[d] ? 1'b0 : rd[d]));
                chk($sformatf("mem_inst%0d", d), inst[d], m_inst[d]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Count busy cycles after the accepting edge until busywait falls.
    task automatic wait_low(input int d, output int n);
        @(posedge clock);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (!bw[d]) break;
            n++;
        end
    endtask

    initial begin
        int           n;
        logic [127:0] exp;
        logic [7:0]   old_b;
        logic [7:0]   new_b;
        logic [5:0]   bits;
        logic [127:0] i0;

        lat[0] = LAT0;
        lat[1] = LAT1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; ad[d] = '0; le[d] = 0; la[d] = '0; lb[d] = '0;
        end
        step(2);
        reset = 0;

        for (int a = 0; a < 1024; a++) begin
            for (int d = 0; d < 2; d++) begin
                le[d] = 1;
                la[d] = 10'(a);
                lb[d] = (a < 16) ? 8'(a) : 8'($urandom);
            end
            step(1);
        end
        le[0] = 0;
        le[1] = 0;
        step(1);

        // Known block 0 pattern.
        rd[0] = 1; ad[0] = 6'd0;
        wait_low(0, n);
        chk("t1_busy_cycles", 128'(n), 128'(5));
        chk("t1_block0", inst[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t1_word0", 128'(inst[0][31:0]), 128'h03020100);
        step(1);
        rd[0] = 0;
        step(1);

        // Reset mid-read, then a fresh full-latency read.
        rd[0] = 1; ad[0] = 6'd3;
        step(3);
        reset = 1;
        step(1);
        reset = 0;
        @(negedge clock);
        chk("t2_inst_cleared", inst[0], 128'd0);
        chk("t2_busy_after_reset", 128'(bw[0]), 128'(1));
        wait_low(0, n);
        chk("t2_busy_cycles", 128'(n), 128'(5));
        chk("t2_block3", inst[0], blk(0, 6'd3));
        step(1);
        rd[0] = 0;
        step(1);

        // Address changes mid-read are ignored.
        rd[0] = 1; ad[0] = 6'd5;
        step(2);
        ad[0] = 6'd9;
        wait_low(0, n);
        chk("t3_block5", inst[0], blk(0, 6'd5));
        step(1);
        rd[0] = 0;
        step(1);

        // Abort then fresh read of block 7.
        i0 = inst[0];
        rd[0] = 1; ad[0] = 6'd2;
        step(2);
        rd[0] = 0;
        step(1);
        chk("t4_inst_held", inst[0], i0);
        rd[0] = 1; ad[0] = 6'd7;
        wait_low(0, n);
        chk("t4_busy_cycles", 128'(n), 128'(5));
        chk("t4_block7", inst[0], blk(0, 6'd7));
        step(1);
        rd[0] = 0;
        step(1);

        // Preload dropped during READ, honoured in IDLE with a request.
        old_b = mmem[0][10'h010];
        new_b = ~old_b;
        rd[0] = 1; ad[0] = 6'd1;
        step(1);
        le[0] = 1; la[0] = 10'h010; lb[0] = new_b;
        step(1);
        le[0] = 0;
        n = 0;
        for (int k = 0; k < 40 && bw[0]; k++) begin
            @(negedge clock);
        end
        chk("t5_write_dropped", 128'(inst[0][7:0]), 128'(old_b));
        step(1);
        rd[0] = 0;
        step(1);
        le[0] = 1; la[0] = 10'h010; lb[0] = new_b;
        rd[0] = 1; ad[0] = 6'd1;
        step(1);
        le[0] = 0;
        @(negedge clock);
        wait_low(0, n);
        chk("t5_write_seen", 128'(inst[0][7:0]), 128'(new_b));
        step(1);
        rd[0] = 0;
        step(1);

        // LATENCY=1 back-to-back with mem_read held.
        rd[1] = 1; ad[1] = 6'd0;
        exp = blk(1, 6'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bits[i] = bw[1];
            if (i == 2) begin
                chk("t6_block0", inst[1], exp);
                ad[1] = 6'd1;
            end
            if (i == 5) chk("t6_block1", inst[1], blk(1, 6'd1));
        end
        chk("t6_busy_pattern", 128'(bits), 128'(6'b011011));
        step(1);
        rd[1] = 0;
        step(1);

        // Randomized traffic on both builds.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 9) < 2) rd[d] = ~rd[d];
                if ($urandom_range(0, 3) == 0) ad[d] = 6'($urandom);
                le[d] = !reset && ($urandom_range(0, 4) == 0);
                la[d] = 10'($urandom);
                lb[d] = 8'($urandom);
            end
            step(1);
        end
        reset = 0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0;
            le[d] = 0;
        end
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
